// File: rtl/counter_mc_pkg.sv
// Shared types and default parameters for the multi-channel up/down counter.
//   op_e   : command opcode carried on the command bus
//   mode_e : overflow/underflow handling for one command
package counter_mc_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_INCR = 2'b01,
        OP_DECR = 2'b10,
        OP_ILL  = 2'b11
    } op_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefNumCh = 4;
    localparam int unsigned DefStepW = 4;

endpackage

// File: rtl/counter_mc_if.sv
// Command / readback bus of counter_mc.
//   master : drives valid, ch_sel, op, step, mode, clr, rd_ch;
//            observes rd_count, incr_decr_error, err_sticky, ovf, unf
//   slave  : the counter itself (directions reversed)
interface counter_mc_if
    import counter_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned STEP_W = DefStepW
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              valid;
    logic [CH_W-1:0]   ch_sel;
    op_e               op;
    logic [STEP_W-1:0] step;
    mode_e             mode;
    logic              clr;
    logic [CH_W-1:0]   rd_ch;
    logic [WIDTH-1:0]  rd_count;
    logic              incr_decr_error;
    logic [NUM_CH-1:0] err_sticky;
    logic              ovf;
    logic              unf;

    modport master (
        output valid, ch_sel, op, step, mode, clr, rd_ch,
        input  rd_count, incr_decr_error, err_sticky, ovf, unf
    );

    modport slave (
        input  valid, ch_sel, op, step, mode, clr, rd_ch,
        output rd_count, incr_decr_error, err_sticky, ovf, unf
    );

endinterface

// File: rtl/counter_mc_alu.sv
// Combinational next-value logic for one channel count.
//   count      : current count
//   op, step   : command and its magnitude
//   mode       : wrap or saturate on over/underflow
//   next_count : updated count (unchanged for nop/illegal)
//   ovf / unf  : result left the 0 .. 2^WIDTH-1 range before wrap/saturate
module counter_mc_alu
    import counter_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned STEP_W = DefStepW
) (
    input  logic [WIDTH-1:0]  count,
    input  op_e               op,
    input  logic [STEP_W-1:0] step,
    input  mode_e             mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              ovf,
    output logic              unf
);

    // One extra bit: carry out of the add, borrow out of the subtract.
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign step_ext = (WIDTH + 1)'(step);
    assign sum      = {1'b0, count} + step_ext;
    assign diff     = {1'b0, count} - step_ext;

    always_comb begin
        next_count = count;
        ovf        = 1'b0;
        unf        = 1'b0;
        unique case (op)
            OP_INCR: begin
                ovf        = sum[WIDTH];
                next_count = (sum[WIDTH] && mode == MODE_SAT) ? '1 : sum[WIDTH-1:0];
            end
            OP_DECR: begin
                unf        = diff[WIDTH];
                next_count = (diff[WIDTH] && mode == MODE_SAT) ? '0 : diff[WIDTH-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/counter_mc.sv
// Multi-channel up/down event counter.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : command bus (valid/ch_sel/op/step/mode/clr), readback select rd_ch,
//         registered outputs rd_count, incr_decr_error, err_sticky, ovf, unf
module counter_mc
    import counter_mc_pkg::*;
#(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned STEP_W = DefStepW
) (
    input  logic         clk,
    input  logic         rst,
    counter_mc_if.slave  bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [WIDTH-1:0]  count_d [NUM_CH];
    logic [NUM_CH-1:0] sticky_q, sticky_d;
    logic [WIDTH-1:0]  rd_q, rd_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] sel_oh;
    logic              ch_ok;
    logic [WIDTH-1:0]  sel_count;
    logic [WIDTH-1:0]  alu_next;
    logic              alu_ovf;
    logic              alu_unf;

    // Channel decode; an out-of-range ch_sel/rd_ch matches nothing, so
    // sel_oh is all zero and rd_d stays 0.
    always_comb begin
        sel_oh    = '0;
        sel_count = '0;
        rd_d      = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.ch_sel == CH_W'(i)) begin
                sel_oh[i] = 1'b1;
                sel_count = count_q[i];
            end
            if (bus.rd_ch == CH_W'(i)) begin
                rd_d = count_q[i];
            end
        end
    end

    assign ch_ok = |sel_oh;

    counter_mc_alu #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_alu (
        .count      (sel_count),
        .op         (bus.op),
        .step       (bus.step),
        .mode       (bus.mode),
        .next_count (alu_next),
        .ovf        (alu_ovf),
        .unf        (alu_unf)
    );

    // clr wins over any same-cycle command; an out-of-range clr is ignored
    // and the command (if any) is then handled normally.
    always_comb begin
        count_d  = count_q;
        sticky_d = sticky_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        err_d    = 1'b0;
        if (bus.clr && ch_ok) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sel_oh[i]) count_d[i] = '0;
            end
            sticky_d = sticky_q & ~sel_oh;
        end else if (bus.valid) begin
            if (bus.op == OP_ILL || !ch_ok) begin
                err_d    = 1'b1;
                sticky_d = sticky_q | sel_oh;
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (sel_oh[i]) count_d[i] = alu_next;
                end
                ovf_d = alu_ovf;
                unf_d = alu_unf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
            end
            sticky_q <= '0;
            rd_q     <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            sticky_q <= sticky_d;
            rd_q     <= rd_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            err_q    <= err_d;
        end
    end

    assign bus.rd_count        = rd_q;
    assign bus.err_sticky      = sticky_q;
    assign bus.ovf             = ovf_q;
    assign bus.unf             = unf_q;
    assign bus.incr_decr_error = err_q;

endmodule

// File: tb/tb_counter_mc.sv
// Self-checking bench for counter_mc: a 4-channel build (d=0) and a 3-channel
// build (d=1, exposes out-of-range ch_sel/rd_ch). A behavioural model predicts
// every cycle's outputs; predictions are queued at drive time and compared
// after the edge.
module tb_counter_mc;
    import counter_mc_pkg::*;

    typedef struct packed {
        logic [7:0] rd;
        logic       ovf;
        logic       unf;
        logic       err;
        logic [3:0] st;
    } obs_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    obs_t exp_q[$];
    obs_t got_q[$];

    int m_cnt[2][4];
    bit m_st[2][4];
    int nch[2];

    counter_mc_if #(.WIDTH(8), .NUM_CH(4), .STEP_W(4)) bus4 ();
    counter_mc_if #(.WIDTH(8), .NUM_CH(3), .STEP_W(4)) bus3 ();

    counter_mc #(.WIDTH(8), .NUM_CH(4), .STEP_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    counter_mc #(.WIDTH(8), .NUM_CH(3), .STEP_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_all();
        bus4.valid = 1'b0; bus4.ch_sel = '0; bus4.op = OP_NOP; bus4.step = '0;
        bus4.mode = MODE_WRAP; bus4.clr = 1'b0; bus4.rd_ch = '0;
        bus3.valid = 1'b0; bus3.ch_sel = '0; bus3.op = OP_NOP; bus3.step = '0;
        bus3.mode = MODE_WRAP; bus3.clr = 1'b0; bus3.rd_ch = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[d][i] = 0;
                m_st[d][i]  = 1'b0;
            end
        end
    endtask

    // Drive one command cycle on DUT d, queue the prediction, sample after the edge.
    task automatic cyc(input int d, input bit v, input int ch, input int op, input int stp,
                       input bit md, input bit cl, input int rc);
        obs_t e;
        obs_t g;
        int   s;
        int   n;
        bit   ok;
        idle_all();
        if (d == 0) begin
            bus4.valid = v; bus4.ch_sel = 2'(ch); bus4.op = op_e'(op[1:0]);
            bus4.step = 4'(stp); bus4.mode = mode_e'(md); bus4.clr = cl; bus4.rd_ch = 2'(rc);
        end else begin
            bus3.valid = v; bus3.ch_sel = 2'(ch); bus3.op = op_e'(op[1:0]);
            bus3.step = 4'(stp); bus3.mode = mode_e'(md); bus3.clr = cl; bus3.rd_ch = 2'(rc);
        end
        n  = nch[d];
        ok = (ch < n);
        e  = '0;
        e.rd = (rc < n) ? 8'(m_cnt[d][rc]) : 8'd0;
        if (cl && ok) begin
            m_cnt[d][ch] = 0;
            m_st[d][ch]  = 1'b0;
        end else if (v) begin
            if (op == 3 || !ok) begin
                e.err = 1'b1;
                if (ok) m_st[d][ch] = 1'b1;
            end else if (op == 1) begin
                s = m_cnt[d][ch] + stp;
                if (s > 255) begin
                    e.ovf = 1'b1;
                    s = md ? 255 : s - 256;
                end
                m_cnt[d][ch] = s;
            end else if (op == 2) begin
                if (stp > m_cnt[d][ch]) begin
                    e.unf = 1'b1;
                    s = md ? 0 : m_cnt[d][ch] - stp + 256;
                end else begin
                    s = m_cnt[d][ch] - stp;
                end
                m_cnt[d][ch] = s;
            end
        end
        for (int i = 0; i < 4; i++) e.st[i] = (i < n) ? m_st[d][i] : 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (d == 0) begin
            g.rd = bus4.rd_count; g.ovf = bus4.ovf; g.unf = bus4.unf;
            g.err = bus4.incr_decr_error; g.st = bus4.err_sticky;
        end else begin
            g.rd = bus3.rd_count; g.ovf = bus3.ovf; g.unf = bus3.unf;
            g.err = bus3.incr_decr_error; g.st = {1'b0, bus3.err_sticky};
        end
        got_q.push_back(g);
    endtask

    task automatic test_reset();
        obs_t e, g;
        idle_all();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus4.rd_count, bus4.ovf, bus4.unf, bus4.incr_decr_error, bus4.err_sticky} !== 15'd0)
        begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus4.rd_count, bus4.ovf, bus4.unf, bus4.incr_decr_error, bus4.err_sticky});
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, c);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL reset_read got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_incr();
        obs_t e, g;
        cyc(0, 1'b1, 1, 1, 3, 1'b0, 1'b0, 1);
        cyc(0, 1'b1, 1, 1, 3, 1'b0, 1'b0, 1);
        cyc(0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1);
        total++;
        if (bus4.rd_count !== 8'd6) begin
            bad++; $display("FAIL incr_ch1 got=%0d want=6", bus4.rd_count);
        end
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2);
        cyc(0, 1'b1, 1, 1, 0, 1'b0, 1'b0, 3);   // step 0: no change, no flags
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL incr got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_ovf();
        obs_t e, g;
        cyc(0, 1'b1, 0, 2, 6, 1'b0, 1'b0, 0);   // 0 - 6 wraps to 250
        cyc(0, 1'b1, 0, 1, 9, 1'b0, 1'b0, 0);
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        total++;
        if (bus4.rd_count !== 8'd3) begin
            bad++; $display("FAIL ovf_wrap got=%0d want=3", bus4.rd_count);
        end
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 0);
        cyc(0, 1'b1, 0, 2, 6, 1'b0, 1'b0, 0);
        cyc(0, 1'b1, 0, 1, 9, 1'b1, 1'b0, 0);
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        total++;
        if (bus4.rd_count !== 8'd255) begin
            bad++; $display("FAIL ovf_sat got=%0d want=255", bus4.rd_count);
        end
        cyc(0, 1'b1, 0, 1, 0, 1'b1, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL ovf got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_unf();
        obs_t e, g;
        cyc(0, 1'b1, 2, 1, 2, 1'b0, 1'b0, 2);
        cyc(0, 1'b1, 2, 2, 5, 1'b0, 1'b0, 2);
        cyc(0, 1'b0, 2, 0, 0, 1'b0, 1'b0, 2);
        total++;
        if (bus4.rd_count !== 8'd253) begin
            bad++; $display("FAIL unf_wrap got=%0d want=253", bus4.rd_count);
        end
        cyc(0, 1'b0, 2, 0, 0, 1'b0, 1'b1, 2);
        cyc(0, 1'b1, 2, 1, 2, 1'b0, 1'b0, 2);
        cyc(0, 1'b1, 2, 2, 5, 1'b1, 1'b0, 2);
        cyc(0, 1'b1, 2, 1, 2, 1'b0, 1'b0, 2);
        cyc(0, 1'b1, 2, 2, 2, 1'b0, 1'b0, 2);   // exact landing on 0
        cyc(0, 1'b0, 2, 0, 0, 1'b0, 1'b0, 2);
        total++;
        if (bus4.unf !== 1'b0) begin
            bad++; $display("FAIL unf_exact got=%b want=0", bus4.unf);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL unf got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_illegal();
        obs_t e, g;
        cyc(0, 1'b1, 3, 1, 4, 1'b0, 1'b0, 3);
        cyc(0, 1'b1, 3, 3, 7, 1'b0, 1'b0, 3);
        cyc(0, 1'b0, 3, 0, 0, 1'b0, 1'b0, 3);
        total++;
        if (bus4.err_sticky !== 4'b1000 || bus4.incr_decr_error !== 1'b0) begin
            bad++;
            $display("FAIL illegal_sticky got=%b/%b want=1000/0",
                     bus4.err_sticky, bus4.incr_decr_error);
        end
        cyc(0, 1'b0, 3, 0, 0, 1'b0, 1'b1, 3);
        cyc(0, 1'b0, 3, 0, 0, 1'b0, 1'b0, 3);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL illegal got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_clr_priority();
        obs_t e, g;
        cyc(0, 1'b1, 1, 1, 15, 1'b0, 1'b1, 1);
        cyc(0, 1'b0, 1, 0, 0, 1'b0, 1'b0, 1);
        total++;
        if (bus4.rd_count !== 8'd0 || bus4.ovf !== 1'b0) begin
            bad++; $display("FAIL clr_prio got=%0d want=0", bus4.rd_count);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL clr_prio got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_out_of_range();
        obs_t e, g;
        cyc(1, 1'b1, 2, 1, 7, 1'b0, 1'b0, 2);
        cyc(1, 1'b1, 3, 1, 5, 1'b0, 1'b0, 3);   // ch_sel 3 >= NUM_CH
        cyc(1, 1'b1, 3, 1, 5, 1'b0, 1'b1, 2);   // clr ignored, command still illegal
        cyc(1, 1'b0, 3, 0, 0, 1'b0, 1'b1, 2);
        cyc(1, 1'b1, 1, 3, 1, 1'b0, 1'b0, 3);
        cyc(1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 2);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL out_of_range got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        for (int k = 0; k < 20; k++) cyc(0, 1'b1, 3, 1, 15, k[0], 1'b0, 3);
        for (int k = 0; k < 80; k++) begin
            cyc(k % 2, ($urandom_range(3) != 0), $urandom_range(3), $urandom_range(3),
                $urandom_range(15), $urandom_range(1), ($urandom_range(7) == 0),
                $urandom_range(3));
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL back_to_back got=%h want=%h", g, e); end
        end
    endtask

    task automatic test_async_reset();
        obs_t e, g;
        cyc(0, 1'b1, 0, 1, 5, 1'b0, 1'b0, 0);
        cyc(0, 1'b1, 0, 1, 15, 1'b0, 1'b0, 0);
        cyc(0, 1'b1, 3, 3, 0, 1'b0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL pre_reset got=%h want=%h", g, e); end
        end
        bus4.valid = 1'b1; bus4.ch_sel = 2'd0; bus4.op = OP_INCR; bus4.step = 4'd7;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({bus4.rd_count, bus4.ovf, bus4.unf, bus4.incr_decr_error, bus4.err_sticky} !== 15'd0)
        begin
            bad++;
            $display("FAIL async_reset got=%h want=0",
                     {bus4.rd_count, bus4.ovf, bus4.unf, bus4.incr_decr_error, bus4.err_sticky});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        cyc(0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) begin bad++; $display("FAIL post_reset got=%h want=%h", g, e); end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        nch[0] = 4;
        nch[1] = 3;
        rst    = 1'b1;
        idle_all();
        #3;
        test_reset();
        test_incr();
        test_ovf();
        test_unf();
        test_illegal();
        test_clr_priority();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_mc.md
Name: counter_mc

Overview:
- Multi-channel up/down event counter; parametrised successor of the single-channel incr/decr counter in the taxi verification environment.
- Holds NUM_CH independent WIDTH-bit counts, updated by a valid-qualified command bus with a per-command step.
- Per-command wrap or saturate mode; overflow/underflow and illegal-command reporting; registered readback port.
- Driven by the tx_intf-style BFM; checked by monitor/scoreboard.

Parameters:
- WIDTH, 8, bits per channel count.
- NUM_CH, 4, number of channels (≥2).
- STEP_W, 4, width of the step operand.
- CH_W, $clog2(NUM_CH), channel index width (localparam, derived).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid  in  1  command qualifier.
- ch_sel  in  CH_W  target channel.
- op  in  2  00 nop, 01 incr, 10 decr, 11 illegal.
- step  in  STEP_W  magnitude of incr/decr.
- mode  in  1  0 wrap, 1 saturate.
- clr  in  1  clear channel ch_sel (independent of valid).
- rd_ch  in  CH_W  readback channel select.
- rd_count  out  WIDTH  registered count of rd_ch.
- incr_decr_error  out  1  one-cycle pulse on illegal command.
- err_sticky  out  NUM_CH  per-channel sticky error.
- ovf  out  1  one-cycle pulse, incr crossed 2^WIDTH-1.
- unf  out  1  one-cycle pulse, decr crossed 0.

Behaviour:
- Reset (rst=0, async): all counts 0, rd_count 0, incr_decr_error 0, err_sticky 0, ovf 0, unf 0. Reset mid-operation discards any command sampled that cycle.
- All updates on rising clk; all outputs registered; latency 1 cycle from command sample to count/flag update.
- valid=0: no count change; op/step ignored; ovf/unf/incr_decr_error low next cycle.
- Incr: sum = count + step, computed at WIDTH+1 bits. If sum > 2^WIDTH-1: wrap → count = sum mod 2^WIDTH; saturate → count = 2^WIDTH-1; ovf pulses in both modes.
- Decr: if step > count: wrap → count = count - step mod 2^WIDTH; saturate → count = 0; unf pulses in both modes.
- Exact landing on max or 0 does not raise ovf/unf.
- step=0 with incr/decr: no change, no flags.
- Illegal command (valid=1 and op=11, or ch_sel ≥ NUM_CH): count unchanged; incr_decr_error pulses; err_sticky[ch_sel] set if ch_sel < NUM_CH.
- clr=1: count[ch_sel] ← 0 and err_sticky[ch_sel] ← 0. clr beats a same-cycle valid command: command dropped, no flags. clr with ch_sel ≥ NUM_CH is ignored.
- Other channels are never affected by a command or clr.
- rd_count: registered each cycle from count[rd_ch] as held before the same edge's update (pre-update value). Update visible on rd_count 2 cycles after the command when rd_ch is held. rd_ch ≥ NUM_CH reads 0.
- Back-to-back commands to the same channel every cycle are supported with no stall; each uses the result of the previous.

Decomposition:
- counter_mc_pkg:
  - op_e enum (OP_NOP, OP_INCR, OP_DECR, OP_ILL).
  - mode_e enum (MODE_WRAP, MODE_SAT).
  - Default parameter constants.
- Sub-module counter_mc_alu: combinational next-value/ovf/unf for one count (count, op, step, mode → next, ovf, unf). Instantiated once on the selected channel.
- Top holds the channel register array, error logic, clr priority and readback register.

Test Plan (WIDTH=8, NUM_CH=4, STEP_W=4):
- Reset, then incr ch1 step 3 ×2 → rd_count(rd_ch=1) = 6; other channels read 0; no flags.
- ch0 preset to 250; incr step 9, mode wrap → count 3, ovf=1 for one cycle. Repeat from 250 with mode sat → count 255, ovf=1.
- ch2 = 2; decr step 5: wrap → 253, unf=1; sat → 0, unf=1. Decr 2 from 2 → 0, unf=0.
- valid with op=11 on ch3 → incr_decr_error pulse, err_sticky=4'b1000, count unchanged. ch_sel=4 is out of range (CH_W=2 cannot encode it), so this case is covered by a NUM_CH=3 build. clr ch3 → err_sticky=0.
- clr and valid incr on ch1 (count 6) in the same cycle → ch1 = 0, no ovf. Assert rst low mid-stream → all outputs 0 immediately, without waiting for a clock edge.
